lane_score_tracker: RTL and testbench

- Parametrised scoring and judgement engine for the drum game.
- Judges NUM_LANES falling notes against the hit bar once per video frame.
- Keeps score, combo, multiplier and miss count; declares game over at a miss limit.
- Sits between the note-scroll generators and the HUD/score display; replaces single-position equality scoring with a hit window, button presses, per-note judgement and saturation.

---
 rtl/lane_score_tracker.sv | 184 ++++++++++++++++++
 tb/tb_lane_score_tracker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_score_tracker.sv
// rtl/lane_score_tracker.sv - per-frame note judgement, score/combo/multiplier and game-over engine
//
// Judges NUM_LANES falling notes against the hit bar on each frame_tick and
// keeps the running score, combo, multiplier and miss count for the HUD.
//
// Ports:
//   clk, reset   system clock; synchronous active-high reset
//   frame_tick   one-clk pulse per video frame; all judgement happens here
//   note_valid   per-lane live-note flag
//   note_pos     packed note y positions, lane i at [i*POS_W +: POS_W]
//   hit_btn      debounced button levels, one per lane
//   score        accumulated score (saturating)
//   combo        consecutive-hit count (saturating)
//   multiplier   current score multiplier, 1..MAX_MULT
//   misses       late-miss count, saturating at MISS_LIMIT
//   hit_pulse    one-clk per-lane hit strobe
//   miss_pulse   one-clk strobe for any late-miss or bad press
//   game_over    high once MISS_LIMIT misses have been reached
module lane_score_tracker #(
  parameter int NUM_LANES  = 5,
  parameter int POS_W      = 10,
  parameter int HIT_Y      = 400,
  parameter int HIT_WIN    = 8,
  parameter int SCORE_W    = 13,
  parameter int COMBO_W    = 8,
  parameter int COMBO_STEP = 8,
  parameter int MAX_MULT   = 4,
  parameter int MISS_LIMIT = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [NUM_LANES-1:0]       note_valid,
  input  logic [NUM_LANES*POS_W-1:0] note_pos,
  input  logic [NUM_LANES-1:0]       hit_btn,
  output logic [SCORE_W-1:0]         score,
  output logic [COMBO_W-1:0]         combo,
  output logic [2:0]                 multiplier,
  output logic [3:0]                 misses,
  output logic [NUM_LANES-1:0]       hit_pulse,
  output logic                       miss_pulse,
  output logic                       game_over
);

  localparam int POS_MAX = (1 << POS_W) - 1;
  localparam int WIN_LO  = (HIT_Y > HIT_WIN) ? HIT_Y - HIT_WIN : 0;
  localparam int WIN_HI  = (HIT_Y + HIT_WIN > POS_MAX) ? POS_MAX : HIT_Y + HIT_WIN;
  localparam logic [POS_W-1:0] WIN_LO_P = POS_W'(WIN_LO);
  localparam logic [POS_W-1:0] WIN_HI_P = POS_W'(WIN_HI);
  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  // Wide enough for score_max + NUM_LANES * 7 and combo_max + NUM_LANES.
  localparam int SUM_W  = SCORE_W + CNT_W + 3;
  localparam int CSUM_W = COMBO_W + CNT_W;

  typedef enum logic {PLAYING, GAME_OVER} state_t;

  state_t                 state_q, state_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [COMBO_W-1:0]     combo_q, combo_d;
  logic [2:0]             mult_q, mult_d;
  logic [3:0]             misses_q, misses_d;
  logic [NUM_LANES-1:0]   hit_pulse_q, hit_pulse_d;
  logic                   miss_pulse_q, miss_pulse_d;
  logic [NUM_LANES-1:0]   press_q, press_d;
  logic [NUM_LANES-1:0]   judged_q, judged_d;
  logic [NUM_LANES-1:0]   btn_prev_q;

  logic [NUM_LANES-1:0]   above, in_win, below;
  logic [NUM_LANES-1:0]   live, hit, late, rise;
  logic                   play_tick, bad;
  logic [CNT_W-1:0]       nh, nm;
  logic [SUM_W-1:0]       score_sum;
  logic [CSUM_W-1:0]      combo_sum;
  logic [7:0]             miss_sum;
  logic [31:0]            mult_quot;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [POS_W-1:0] pos;
    assign pos       = note_pos[g*POS_W +: POS_W];
    assign above[g]  = pos < WIN_LO_P;
    assign in_win[g] = (pos >= WIN_LO_P) && (pos <= WIN_HI_P);
    assign below[g]  = pos > WIN_HI_P;
  end

  assign play_tick = frame_tick && (state_q == PLAYING);
  assign live      = note_valid & ~judged_q;
  assign hit       = {NUM_LANES{play_tick}} & live & press_q & in_win;
  assign late      = {NUM_LANES{play_tick}} & live & below;
  assign bad       = play_tick && (|(press_q & ~hit));
  assign rise      = hit_btn & ~btn_prev_q;

  // A judged note stays judged until its lane empties or a fresh note
  // appears above the window, so one note can never score twice.
  assign judged_d  = (judged_q & note_valid & ~above) | hit | late;

  always_comb begin
    nh = '0;
    nm = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      nh = nh + CNT_W'(hit[i]);
      nm = nm + CNT_W'(late[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    combo_d      = combo_q;
    mult_d       = mult_q;
    misses_d     = misses_q;
    hit_pulse_d  = '0;
    miss_pulse_d = 1'b0;
    score_sum    = SUM_W'(score_q) + SUM_W'(nh) * SUM_W'(mult_q);
    combo_sum    = CSUM_W'(combo_q) + CSUM_W'(nh);
    miss_sum     = 8'(misses_q) + 8'(nm);
    mult_quot    = '0;
    if (play_tick) begin
      // Hits score at the multiplier that was in force before this frame.
      score_d = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
      if (nm != '0 || bad) begin
        combo_d = '0;
      end else begin
        combo_d = (combo_sum > CSUM_W'({COMBO_W{1'b1}})) ? '1 : combo_sum[COMBO_W-1:0];
      end
      mult_quot = 32'(combo_d) / 32'(COMBO_STEP) + 32'd1;
      mult_d    = (mult_quot > 32'(MAX_MULT)) ? 3'(MAX_MULT) : mult_quot[2:0];
      if (miss_sum >= 8'(MISS_LIMIT)) begin
        misses_d = 4'(MISS_LIMIT);
        state_d  = GAME_OVER;
      end else begin
        misses_d = miss_sum[3:0];
      end
      hit_pulse_d  = hit;
      miss_pulse_d = (nm != '0) || bad;
    end
  end

  // Presses are consumed by each frame_tick; an edge arriving on the tick
  // cycle itself carries into the next frame. Latches stay empty once over.
  always_comb begin
    press_d = press_q | rise;
    if (state_d == GAME_OVER) begin
      press_d = '0;
    end else if (frame_tick) begin
      press_d = rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLAYING;
      score_q      <= '0;
      combo_q      <= '0;
      mult_q       <= 3'd1;
      misses_q     <= '0;
      hit_pulse_q  <= '0;
      miss_pulse_q <= 1'b0;
      press_q      <= '0;
      judged_q     <= '0;
      // Track the level so a button held through reset is not a new press.
      btn_prev_q   <= hit_btn;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      mult_q       <= mult_d;
      misses_q     <= misses_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      press_q      <= press_d;
      judged_q     <= judged_d;
      btn_prev_q   <= hit_btn;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign multiplier = mult_q;
  assign misses     = misses_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign game_over  = (state_q == GAME_OVER);

endmodule

// File: tb/tb_lane_score_tracker.sv
// tb/tb_lane_score_tracker.sv - self-checking bench for lane_score_tracker
module tb_lane_score_tracker;

  localparam int NL    = 5;
  localparam int PW    = 10;
  localparam int WLO   = 392;
  localparam int WHI   = 408;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            frame_tick = 1'b0;
  logic [NL-1:0]   note_valid = '0;
  logic [NL*PW-1:0] note_pos = '0;
  logic [NL-1:0]   hit_btn = '0;

  logic [12:0]     score;
  logic [7:0]      combo;
  logic [2:0]      multiplier;
  logic [3:0]      misses;
  logic [NL-1:0]   hit_pulse;
  logic            miss_pulse;
  logic            game_over;

  logic [5:0]      score_s;
  logic [2:0]      combo_s;
  logic [2:0]      mult_s;
  logic [3:0]      misses_s;
  logic [NL-1:0]   hit_pulse_s;
  logic            miss_pulse_s;
  logic            game_over_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lane_score_tracker dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .note_valid(note_valid),
    .note_pos(note_pos), .hit_btn(hit_btn), .score(score), .combo(combo),
    .multiplier(multiplier), .misses(misses), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .game_over(game_over)
  );

  lane_score_tracker #(.SCORE_W(6), .COMBO_W(3), .COMBO_STEP(2)) dut_s (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .note_valid(note_valid),
    .note_pos(note_pos), .hit_btn(hit_btn), .score(score_s), .combo(combo_s),
    .multiplier(mult_s), .misses(misses_s), .hit_pulse(hit_pulse_s),
    .miss_pulse(miss_pulse_s), .game_over(game_over_s)
  );

  // Reference model: game rules applied once per clock with plain integers.
  bit m_press[NL], m_judged[NL], m_prev[NL];
  int m_score, m_combo, m_mult, m_score_s, m_combo_s, m_mult_s, m_misses, m_hitp;
  bit m_over, m_missp;

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    int nh, nm, p, hitv;
    bit bad, tk, h, l, live, r;
    if (reset) begin
      for (int i = 0; i < NL; i++) begin
        m_press[i] = 0; m_judged[i] = 0; m_prev[i] = hit_btn[i];
      end
      m_score = 0; m_combo = 0; m_mult = 1; m_score_s = 0; m_combo_s = 0; m_mult_s = 1;
      m_misses = 0; m_over = 0; m_hitp = 0; m_missp = 0;
      return;
    end
    tk = frame_tick && !m_over;
    nh = 0; nm = 0; bad = 0; hitv = 0;
    for (int i = 0; i < NL; i++) begin
      p    = int'(note_pos[i*PW +: PW]);
      live = note_valid[i] && !m_judged[i];
      h    = tk && live && m_press[i] && p >= WLO && p <= WHI;
      l    = tk && live && p > WHI;
      if (tk && m_press[i] && !h) bad = 1;
      nh += int'(h); nm += int'(l);
      if (h) hitv |= (1 << i);
      m_judged[i] = (m_judged[i] && note_valid[i] && p >= WLO) || h || l;
    end
    if (tk) begin
      m_score   = min2(m_score + nh * m_mult, 8191);
      m_score_s = min2(m_score_s + nh * m_mult_s, 63);
      if (nm > 0 || bad) begin
        m_combo = 0; m_combo_s = 0;
      end else begin
        m_combo = min2(m_combo + nh, 255); m_combo_s = min2(m_combo_s + nh, 7);
      end
      m_mult   = min2(1 + m_combo / 8, 4);
      m_mult_s = min2(1 + m_combo_s / 2, 4);
      m_misses = m_misses + nm;
      if (m_misses >= 5) begin m_misses = 5; m_over = 1; end
      m_hitp  = hitv;
      m_missp = (nm > 0) || bad;
    end else begin
      m_hitp = 0; m_missp = 0;
    end
    for (int i = 0; i < NL; i++) begin
      r = hit_btn[i] && !m_prev[i];
      if (m_over) m_press[i] = 0;
      else if (frame_tick) m_press[i] = r;
      else m_press[i] = m_press[i] || r;
      m_prev[i] = hit_btn[i];
    end
  endtask

  task automatic tick_clk();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input bit v, input int p);
    note_valid[i] = v;
    note_pos[i*PW +: PW] = PW'(p);
  endtask

  task automatic do_reset();
    frame_tick = 0; hit_btn = '0; note_valid = '0; note_pos = '0;
    reset = 1; tick_clk(); tick_clk(); reset = 0;
  endtask

  task automatic press(input logic [NL-1:0] mask);
    hit_btn = mask; tick_clk(); hit_btn = '0; tick_clk();
  endtask

  task automatic frame();
    frame_tick = 1; tick_clk(); frame_tick = 0;
  endtask

  task automatic test_reset();
    reset = 1; frame_tick = 1; hit_btn = '1; note_valid = '1;
    tick_clk(); tick_clk();
    reset = 0; frame_tick = 0; hit_btn = '0; note_valid = '0;
    n_vec++; if (score !== 13'd0) begin n_err++; $display("FAIL reset_score got=%0d exp=0", score); end
    n_vec++; if (combo !== 8'd0) begin n_err++; $display("FAIL reset_combo got=%0d exp=0", combo); end
    n_vec++; if (multiplier !== 3'd1) begin n_err++; $display("FAIL reset_mult got=%0d exp=1", multiplier); end
    n_vec++; if (misses !== 4'd0) begin n_err++; $display("FAIL reset_misses got=%0d exp=0", misses); end
    n_vec++; if (hit_pulse !== 5'd0 || miss_pulse !== 1'b0 || game_over !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got=%b/%b/%b exp=0/0/0", hit_pulse, miss_pulse, game_over);
    end
  endtask

  task automatic test_hit_combo();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      set_lane(0, 1, 400); press(5'b00001); frame();
      if (k == 0) begin
        n_vec++; if (score !== 13'd1 || combo !== 8'd1 || hit_pulse !== 5'b00001) begin
          n_err++; $display("FAIL first_hit got=%0d/%0d/%b exp=1/1/00001", score, combo, hit_pulse);
        end
      end
      if (k == 7) begin
        n_vec++; if (combo !== 8'd8 || multiplier !== 3'd2) begin
          n_err++; $display("FAIL combo8 got=%0d/%0d exp=8/2", combo, multiplier);
        end
      end
      set_lane(0, 0, 0); tick_clk();
      n_vec++; if (hit_pulse !== 5'd0) begin n_err++; $display("FAIL pulse_width got=%b exp=0", hit_pulse); end
    end
    n_vec++; if (score !== 13'd10) begin n_err++; $display("FAIL mult2_score got=%0d exp=10", score); end
  endtask

  task automatic test_double_count();
    int hits = 0;
    do_reset();
    set_lane(0, 1, 405); press(5'b00001);
    for (int k = 0; k < 3; k++) begin
      frame(); hits += int'(hit_pulse[0]);
    end
    n_vec++; if (hits != 1 || score !== 13'd1) begin
      n_err++; $display("FAIL double_guard got=%0d hits score=%0d exp=1/1", hits, score);
    end
    press(5'b00001); frame();
    n_vec++; if (combo !== 8'd0 || misses !== 4'd0 || miss_pulse !== 1'b1 || hit_pulse !== 5'd0) begin
      n_err++; $display("FAIL bad_press got=%0d/%0d/%b/%b exp=0/0/1/0", combo, misses, miss_pulse, hit_pulse);
    end
  endtask

  task automatic test_hit_and_miss();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_lane(0, 1, 400); press(5'b00001); frame(); set_lane(0, 0, 0); tick_clk();
    end
    n_vec++; if (combo !== 8'd5 || multiplier !== 3'd1) begin
      n_err++; $display("FAIL combo5 got=%0d/%0d exp=5/1", combo, multiplier);
    end
    set_lane(1, 1, 398); set_lane(2, 1, 410); press(5'b00010); frame();
    n_vec++; if (score !== 13'd6 || combo !== 8'd0 || misses !== 4'd1 || miss_pulse !== 1'b1 || hit_pulse !== 5'b00010) begin
      n_err++; $display("FAIL hit_and_miss got=%0d/%0d/%0d/%b/%b exp=6/0/1/1/00010",
                        score, combo, misses, miss_pulse, hit_pulse);
    end
    set_lane(1, 0, 0); set_lane(2, 0, 0); tick_clk();
  endtask

  task automatic test_game_over();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_lane(3, 1, 420); frame();
      n_vec++; if (misses !== 4'(k + 1) || game_over !== (k == 4)) begin
        n_err++; $display("FAIL miss_count k=%0d got=%0d/%b exp=%0d/%0d", k, misses, game_over, k + 1, k == 4);
      end
      set_lane(3, 0, 0); tick_clk();
    end
    for (int k = 0; k < 4; k++) begin
      set_lane(k, 1, 400); set_lane(4, 1, 430); press(5'b01111); frame();
      n_vec++; if (score !== 13'd0 || combo !== 8'd0 || multiplier !== 3'd1 || misses !== 4'd5 ||
                   hit_pulse !== 5'd0 || miss_pulse !== 1'b0 || game_over !== 1'b1) begin
        n_err++; $display("FAIL frozen got=%0d/%0d/%0d/%0d/%b/%b/%b exp=0/0/1/5/0/0/1",
                          score, combo, multiplier, misses, hit_pulse, miss_pulse, game_over);
      end
    end
    do_reset();
    n_vec++; if (score !== 13'd0 || combo !== 8'd0 || multiplier !== 3'd1 || misses !== 4'd0 || game_over !== 1'b0) begin
      n_err++; $display("FAIL go_reset got=%0d/%0d/%0d/%0d/%b exp=0/0/1/0/0",
                        score, combo, multiplier, misses, game_over);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < NL; i++) set_lane(i, 1, 396 + i);
      press(5'b11111); frame();
      n_vec++; if (score !== 13'(m_score) || score_s !== 6'(m_score_s) || combo_s !== 3'(m_combo_s)) begin
        n_err++; $display("FAIL sat_step k=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                          k, score, score_s, combo_s, m_score, m_score_s, m_combo_s);
      end
      note_valid = '0; tick_clk();
    end
    n_vec++; if (score_s !== 6'd63 || combo_s !== 3'd7 || mult_s !== 3'd4) begin
      n_err++; $display("FAIL sat_small got=%0d/%0d/%0d exp=63/7/4", score_s, combo_s, mult_s);
    end
    n_vec++; if (combo !== 8'd255 || multiplier !== 3'd4) begin
      n_err++; $display("FAIL sat_combo got=%0d/%0d exp=255/4", combo, multiplier);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    set_lane(0, 1, 400); press(5'b00001);
    reset = 1; frame_tick = 1; tick_clk(); reset = 0;
    frame_tick = 1; tick_clk(); frame_tick = 0;
    n_vec++; if (hit_pulse !== 5'd0 || score !== 13'd0 || miss_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset_mid got=%b/%0d/%b exp=0/0/0", hit_pulse, score, miss_pulse);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 149) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 15) == 0) note_valid[i] = ~note_valid[i];
        if ($urandom_range(0, 3) == 0) note_pos[i*PW +: PW] = PW'($urandom_range(380, 420));
        if ($urandom_range(0, 6) == 0) hit_btn[i] = ~hit_btn[i];
      end
      tick_clk();
      n_vec++; if (score !== 13'(m_score) || combo !== 8'(m_combo) || multiplier !== 3'(m_mult) ||
                   misses !== 4'(m_misses) || game_over !== m_over) begin
        n_err++; $display("FAIL rnd_main c=%0d got=%0d/%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%0d/%0d",
                          c, score, combo, multiplier, misses, game_over, m_score, m_combo, m_mult, m_misses, m_over);
      end
      n_vec++; if (hit_pulse !== 5'(m_hitp) || miss_pulse !== m_missp ||
                   hit_pulse_s !== 5'(m_hitp) || miss_pulse_s !== m_missp) begin
        n_err++; $display("FAIL rnd_pulse c=%0d got=%b/%b/%b/%b exp=%0b/%0d", c, hit_pulse, miss_pulse,
                          hit_pulse_s, miss_pulse_s, m_hitp, m_missp);
      end
      n_vec++; if (score_s !== 6'(m_score_s) || combo_s !== 3'(m_combo_s) || mult_s !== 3'(m_mult_s) ||
                   misses_s !== 4'(m_misses) || game_over_s !== m_over) begin
        n_err++; $display("FAIL rnd_small c=%0d got=%0d/%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%0d/%0d",
                          c, score_s, combo_s, mult_s, misses_s, game_over_s, m_score_s, m_combo_s, m_mult_s, m_misses, m_over);
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_hit_combo();
    test_double_count();
    test_hit_and_miss();
    test_game_over();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
